// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel: keypad geometry,
// key-map decode and the keypad scanner state encoding.
package microwave_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 12;
  localparam int KEY_STAR = 10;
  localparam int KEY_HASH = 11;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } kscan_state_t;

  // A valid press shows exactly one low column within the driven row.
  function automatic logic is_single_low(input logic [NUM_COLS-1:0] cols);
    return (cols == 3'b110) || (cols == 3'b101) || (cols == 3'b011);
  endfunction

  function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    case (cols)
      3'b110:  idx = 2'd0;
      3'b101:  idx = 2'd1;
      3'b011:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_pattern(input logic [1:0] col);
    return ~(3'b001 << col);
  endfunction

  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  // Key map: (row, col) -> digit index, '*' = 10, '#' = 11.
  function automatic logic [3:0] key_index(input logic [1:0] row,
                                           input logic [1:0] col);
    logic [3:0] idx;
    idx = 4'd0;
    case ({row, col})
      4'b00_00: idx = 4'd1;
      4'b00_01: idx = 4'd2;
      4'b00_10: idx = 4'd3;
      4'b01_00: idx = 4'd4;
      4'b01_01: idx = 4'd5;
      4'b01_10: idx = 4'd6;
      4'b10_00: idx = 4'd7;
      4'b10_01: idx = 4'd8;
      4'b10_10: idx = 4'd9;
      4'b11_00: idx = 4'(KEY_STAR);
      4'b11_01: idx = 4'd0;
      4'b11_10: idx = 4'(KEY_HASH);
      default:  idx = 4'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] idx);
    return NUM_KEYS'(1) << idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones
// so idle active-low lines read as inactive.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep the two stages a true shift;
  // blocking ones would collapse them into a single flop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives one row low at a time, debounces a single
// key press/release and presents it as static one-hot key levels.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash
);

  import microwave_pkg::*;

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);

  logic [NUM_COLS-1:0] cols;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;

  // The local DEBOUNCE parameter hides the state literal of the same name,
  // so that state is always written with its package scope below.
  kscan_state_t        state;
  logic [1:0]          row_idx;
  logic [1:0]          lat_row;
  logic [1:0]          lat_col;
  logic [DEB_W-1:0]    deb_cnt;
  logic [NUM_KEYS-1:0] key_vec;

  logic [1:0]          row_next;
  logic                cols_match;

  sync2 #(.WIDTH(NUM_COLS)) u_col_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (col_n),
    .q      (cols)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick       = (tick_cnt == TICK_LAST);
  assign row_next   = (row_idx == 2'(NUM_ROWS - 1)) ? 2'd0 : row_idx + 2'd1;
  assign cols_match = (cols == col_pattern(lat_col));

  // Row drive and key outputs are registered so the pins and the encoder
  // never see decode glitches; the async reset clears them immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      row_n   <= 4'b1110;
      lat_row <= 2'd0;
      lat_col <= 2'd0;
      deb_cnt <= '0;
      key_vec <= '0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (is_single_low(cols)) begin
            lat_row <= row_idx;
            lat_col <= col_index(cols);
            deb_cnt <= '0;
            state   <= microwave_pkg::DEBOUNCE;
          end else begin
            row_idx <= row_next;
            row_n   <= row_drive(row_next);
          end
        end

        microwave_pkg::DEBOUNCE: begin
          if (!cols_match) begin
            state <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            key_vec <= key_onehot(key_index(lat_row, lat_col));
            state   <= PRESSED;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESSED: begin
          // Any non-matching sample, including multiple lows, counts
          // toward release; one matching sample restarts the count.
          if (cols_match) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            key_vec <= '0;
            state   <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

  assign keypad   = key_vec[9:0];
  assign key_star = key_vec[KEY_STAR];
  assign key_hash = key_vec[KEY_HASH];

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: models the key matrix on row_n/col_n and
// checks press/release latency, debounce, key priority and async reset.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clock;
  logic       resetn;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keypad;
  logic       key_star;
  logic       key_hash;

  logic [2:0]  held [4];
  logic [11:0] obs;
  int checks      = 0;
  int errors      = 0;
  int onehot_viol = 0;

  assign obs = {key_hash, key_star, keypad};

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .col_n    (col_n),
    .row_n    (row_n),
    .keypad   (keypad),
    .key_star (key_star),
    .key_hash (key_hash)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key matrix: a held key shorts its column low while its row is driven.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && held[r][c]) col_n[c] = 1'b0;
  end

  always @(negedge clock)
    if (resetn && $countones(obs) > 1) onehot_viol++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_out(input logic [11:0] exp, input int budget, output int n);
    n = 0;
    while (obs !== exp && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_row(input logic [3:0] exp, input int budget, output int n);
    n = 0;
    while (row_n !== exp && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic watch(input logic [11:0] exp, input int cycles, output int bad);
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (obs !== exp) bad++;
    end
  endtask

  initial begin
    int n;
    int bad;
    int bad2;

    for (int r = 0; r < 4; r++) held[r] = 3'b000;
    resetn = 1'b0;
    step(2);
    check("reset_row", row_n, 4'b1110);
    check("reset_out", obs, 12'h000);

    // Idle scan: one row step every SCAN_DIV clocks.
    resetn = 1'b1;
    step(3); check("scan_row0_hold", row_n, 4'b1110);
    step(1); check("scan_row1", row_n, 4'b1101);
    step(4); check("scan_row2", row_n, 4'b1011);
    step(4); check("scan_row3", row_n, 4'b0111);
    step(4); check("scan_wrap", row_n, 4'b1110);

    // Key 5 held while row 0 is driven: detect at row 1, then 3 ticks.
    held[1][1] = 1'b1;
    wait_out(12'h020, 34, n);
    check("press5_out", obs, 12'h020);
    check("press5_latency", n, 20);
    check("press5_row_frozen", row_n, 4'b1101);

    // Release glitch of two ticks must not drop the output.
    held[1][1] = 1'b0;
    watch(12'h020, 8, bad);
    held[1][1] = 1'b1;
    watch(12'h020, 16, bad2);
    check("release_glitch_hold", bad + bad2, 0);

    held[1][1] = 1'b0;
    wait_out(12'h000, 18, n);
    check("release5_out", obs, 12'h000);
    check("release5_latency", n, 12);
    check("release5_row_still", row_n, 4'b1101);
    wait_row(4'b1011, 8, n);
    check("rescan_row2", row_n, 4'b1011);
    check("rescan_delay", n, 4);

    // Bounce on key 8: toggle every tick for 10 ticks, then hold.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      held[2][1] = (i % 2 == 0);
      watch(12'h000, 4, bad2);
      bad += bad2;
    end
    check("bounce_quiet", bad, 0);
    held[2][1] = 1'b1;
    wait_out(12'h100, 40, n);
    check("bounce_press", obs, 12'h100);
    check("bounce_min_latency", (n >= 12 && n <= 20), 1'b1);
    held[2][1] = 1'b0;
    wait_out(12'h000, 20, n);
    check("bounce_release", obs, 12'h000);

    // Special keys.
    held[3][0] = 1'b1;
    wait_out(12'h400, 48, n);
    check("star_press", obs, 12'h400);
    held[3][0] = 1'b0;
    wait_out(12'h000, 20, n);
    check("star_release", obs, 12'h000);
    held[3][2] = 1'b1;
    wait_out(12'h800, 48, n);
    check("hash_press", obs, 12'h800);
    held[3][2] = 1'b0;
    wait_out(12'h000, 20, n);
    check("hash_release", obs, 12'h000);

    // Two keys in one row are never accepted.
    held[1][0] = 1'b1;
    held[1][2] = 1'b1;
    watch(12'h000, 64, bad);
    check("same_row_quiet", bad, 0);
    held[1][0] = 1'b0;
    held[1][2] = 1'b0;

    // First key wins; the second shows up only after re-scan.
    held[0][1] = 1'b1;
    wait_out(12'h004, 48, n);
    check("key2_press", obs, 12'h004);
    held[2][2] = 1'b1;
    watch(12'h004, 40, bad);
    check("first_key_wins", bad, 0);
    held[0][1] = 1'b0;
    wait_out(12'h200, 80, n);
    check("key9_after_rescan", obs, 12'h200);
    held[2][2] = 1'b0;
    wait_out(12'h000, 20, n);
    check("key9_release", obs, 12'h000);

    // Reset in the middle of a press of key 0.
    held[3][1] = 1'b1;
    wait_out(12'h001, 48, n);
    check("key0_press", obs, 12'h001);
    #2 resetn = 1'b0;
    #1;
    check("reset_async_out", obs, 12'h000);
    check("reset_async_row", row_n, 4'b1110);
    @(negedge clock);
    resetn = 1'b1;
    wait_out(12'h001, 40, n);
    check("key0_repress", obs, 12'h001);
    check("key0_repress_latency", n, 28);
    held[3][1] = 1'b0;
    wait_out(12'h000, 20, n);
    check("key0_release", obs, 12'h000);

    check("onehot_outputs", onehot_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives a 4-row × 3-column matrix keypad and presents debounced key state to the keypad encoder.
- Output: a one-hot `keypad[9:0]` level vector, plus levels for `*` and `#`.
- It is the transmitting end of the keypad interface: the encoder consumes `keypad` exactly as a static switch bank would present it.
- Sits between the front-panel pins and the encoder in the microwave top level.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clock cycles per sample tick. Minimum 4.
- `DEBOUNCE`, 16: consecutive matching sample ticks required to accept a press or a release. Minimum 1.

Ports:
- `clock`  in  1  system clock. All state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `col_n`  in  3  column sense lines, active-low, asynchronous to `clock`.
- `row_n`  out  4  row drive, active-low, exactly one bit low at all times.
- `keypad`  out  10  debounced one-hot digit. Bit k is high while digit k is held.
- `key_star`  out  1  debounced `*` held.
- `key_hash`  out  1  debounced `#` held.

## Operation
- Key map, as (row, col):
  - (0,0..2) = 1,2,3
  - (1,0..2) = 4,5,6
  - (2,0..2) = 7,8,9
  - (3,0) = `*`, (3,1) = 0, (3,2) = `#`
- `col_n` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick counter runs 0..SCAN_DIV-1 and wraps. A sample tick occurs when the count is SCAN_DIV-1.
- State machine:
  - SCAN:
    - At each tick, if the synchronized cols show exactly one low bit: latch row and col, clear the debounce counter, go to DEBOUNCE. The row is frozen.
    - Otherwise advance `row_n` to the next row, wrapping 3→0.
  - DEBOUNCE:
    - At each tick, if the cols equal the latched single-low pattern, increment the counter.
    - On reaching DEBOUNCE, go to PRESSED. The decoded output rises on the same edge.
    - Any mismatch at a tick returns to SCAN. The row then advances at the next tick.
  - PRESSED:
    - The output for the latched key is held high and the row stays frozen.
    - At each tick, a cols value not equal to the latched pattern increments the release counter. A matching tick clears it.
    - On reaching DEBOUNCE, all outputs clear and the state returns to SCAN.
- Multiple lows in one row (two keys in the same row) are invalid. In SCAN they are ignored and the row advances. In DEBOUNCE they count as a mismatch. In PRESSED they count as a non-match toward release.
- Keys in other rows are invisible while the row is frozen: the first key detected wins. After release, scanning resumes from the frozen row + 1.
- At most one of `keypad` bits, `key_star` and `key_hash` is high in any cycle.

## Timing
- Reset, asynchronous:
  - `row_n` = 4'b1110, `keypad` = 0, `key_star` = 0, `key_hash` = 0.
  - State SCAN; tick, debounce and latch registers at 0; synchronizer flops set to 3'b111.
  - Reset asserted mid-press clears outputs immediately, with no glitch to other keys.
- `row_n` changes only on the edge after a SCAN sample tick. The minimum settle time before the next sample is SCAN_DIV-1 cycles, which is why SCAN_DIV ≥ 4 covers the synchronizer plus pin settling.
- Press latency, from a stable press with the row already driven: key output rises on the edge of tick DEBOUNCE after detection. That is (DEBOUNCE+1)·SCAN_DIV cycles, plus up to 2 synchronizer cycles and up to 4·SCAN_DIV scan-alignment cycles.
- Release latency: outputs fall on the edge of the DEBOUNCE-th consecutive released tick.
- A release glitch shorter than DEBOUNCE ticks does not drop the output.

## Structure
- Shared package `microwave_pkg`:
  - state enum `kscan_state_t` {SCAN, DEBOUNCE, PRESSED};
  - key-map constants, (row, col) → digit index, with `*` = 10 and `#` = 11;
  - `NUM_ROWS` = 4, `NUM_COLS` = 3.
- One sub-module, `sync2`: a parameterized-width two-flop synchronizer with reset value all-ones. It is used for `col_n`.
- Everything else lives in `keypad_scanner`: tick counter, FSM, debounce counter, latch, output decode.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE=3. The bench models the matrix by pulling `col_n` low when the driven row matches a held key.

- Reset: hold `resetn`=0, then release → `row_n`=1110, all outputs 0. With no keys held, `row_n` cycles 1110→1101→1011→0111→1110, one step every 4 clocks.
- Single press: hold key 5 (row 1, col 1) steadily → `keypad`=10'b0000100000 within (3+1)·4+2+16 cycles. `row_n` stays 1101 while held. Release → `keypad`=0 after 3 released ticks, then scanning resumes at row 2.
- Bounce: toggle key 8 every tick for 10 ticks, then hold → no output during toggling. `keypad`[8] rises 3 ticks after the toggling ends.
- Special keys: hold `*` → `key_star`=1, `keypad`=0. Release, then hold `#` → `key_hash`=1.
- Simultaneous keys:
  - Hold 4 and 6 (same row) → no output ever.
  - Hold 2, then add 9 → only `keypad`[2]. Release 2 while 9 is still held → `keypad`[9] asserts after re-scan and debounce.
- Reset mid-press: assert `resetn`=0 while `keypad`[0]=1 → `keypad`=0 in the same cycle, without waiting for a clock edge. After reset releases with 0 still held, `keypad`[0] re-asserts after the full press latency.
